// File: rtl/mux8way_pkg.sv
// Shared definitions for the 8-way merge arbiter.
//   N_CH    : number of source channels
//   SEL_W   : width of a channel index
//   rr_pick : round-robin pick; returns {found, idx}. The search starts at
//             channel 'ptr' and proceeds upward with wrap. idx is the first
//             channel in that order whose valid bit is set.
package mux8way_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    function automatic logic [SEL_W:0] rr_pick(input logic [N_CH-1:0]  valid,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] k;
        res = '0;
        // Walk from the farthest offset back to the nearest. The last hit is
        // kept, so it is the channel closest to ptr. k wraps naturally mod 8.
        for (int i = N_CH - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (valid[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8way_rr_pick.sv
// Combinational grant selection: rotate by base, priority-encode, unrotate.
// Ports:
//   valid [N_CH-1:0]  in  : per-channel request flags
//   base  [SEL_W-1:0] in  : highest-priority channel for this cycle
//   found             out : at least one request present
//   idx   [SEL_W-1:0] out : granted channel (0 when nothing found)
module mux8way_rr_pick
    import mux8way_pkg::*;
(
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] base,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W:0] pick;

    assign pick  = rr_pick(valid, base);
    assign found = pick[SEL_W];
    assign idx   = pick[SEL_W-1:0];

endmodule

// File: rtl/mux8way_arbiter.sv
// 8-to-1 valid/ready merge. Words from eight source channels are forwarded
// one per cycle through a single output register. Each word is tagged with
// its source index.
// Build option: MUX8WAY_FIXED_PRIO_EN
//   - When defined, there is no round-robin pointer, and channel 0 always
//     has the highest priority.
//   - When undefined, grants rotate round-robin, starting just past the
//     last granted channel.
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : asynchronous active-high reset
//   in_valid   in  : [7:0] per-channel word present
//   in_data    in  : [8*W-1:0] channel k word at in_data[k*W +: W]
//   in_ready   out : [7:0] one-hot (or zero) accept strobe
//   out_valid  out : output register holds a word
//   out_data   out : [W-1:0] forwarded word
//   out_sel    out : [2:0] source channel of out_data
//   out_ready  in  : downstream accepts the word this cycle
module mux8way_arbiter
    import mux8way_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH*W-1:0]   in_data,
    output logic [N_CH-1:0]     in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_sel,
    input  logic                out_ready
);

    logic             load_ok;
    logic             found;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] base;
    logic [W-1:0]     words [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_words
        assign words[k] = in_data[k*W +: W];
    end

`ifdef MUX8WAY_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [SEL_W-1:0] ptr;

    // The pointer moves just past the granted channel. The 3-bit add wraps 7 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load_ok && found) begin
            ptr <= grant + SEL_W'(1);
        end
    end

    assign base = ptr;
`endif

    mux8way_rr_pick u_pick (
        .valid (in_valid),
        .base  (base),
        .found (found),
        .idx   (grant)
    );

    // The output register may take a new word when it is empty or being drained.
    assign load_ok = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (found && load_ok && !reset) begin
            in_ready = N_CH'(1) << grant;
        end
    end

    // On a consume-plus-grant cycle the old word is replaced in place, so no bubble is inserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_ok) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= words[grant];
                out_sel   <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
